uart_tx_fifo: RTL and testbench

//  Buffered UART transmitter, 8N1, LSB first: drives the txd line of top back to the host.

---
 rtl/uart_tx_fifo.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter with byte FIFO
//
// Purpose:
//   Queues bytes from the core and serialises them on txd, 8 data bits,
//   no parity, one stop bit, LSB first, CLK_PER_BIT clocks per bit.
//   Queued bytes go out back-to-back with no idle gap between frames.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   wr_data     byte to transmit
//   wr_valid    wr_data valid this cycle
//   wr_ready    FIFO not full (registered count, no path from the pop)
//   txd         registered serial output, idle high
//   busy        FIFO non-empty or a frame in progress
//   fifo_count  bytes queued, not counting the byte being shifted

module uart_tx_fifo #(
  parameter int CLK_PER_BIT = 5,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   wr_data,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  output logic                         txd,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLK_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] FULL   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  // Serialiser
  state_t        state;
  state_t        state_n;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_n;
  logic [2:0]    idx;
  logic [2:0]    idx_n;
  logic [7:0]    sh;
  logic [7:0]    sh_n;
  logic          txd_q;
  logic          txd_n;
  logic          timer_end;

  assign fifo_empty = (count == '0);
  // Ready depends only on the registered count, so a full FIFO refuses a
  // write even on an edge where the serialiser pops.
  assign wr_ready   = (count != FULL);
  assign push       = wr_valid && wr_ready;
  assign fifo_count = count;
  assign txd        = txd_q;
  // Built from registered state only, so it cannot glitch inside a frame.
  assign busy       = (state != S_IDLE) || !fifo_empty;
  assign timer_end  = (timer == T_LAST);

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      timer <= '0;
      idx   <= '0;
      sh    <= '0;
      txd_q <= 1'b1;
    end else begin
      state <= state_n;
      timer <= timer_n;
      idx   <= idx_n;
      sh    <= sh_n;
      txd_q <= txd_n;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    idx_n   = idx;
    sh_n    = sh;
    txd_n   = txd_q;
    pop     = 1'b0;

    case (state)
      S_IDLE: begin
        txd_n = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_n    = mem[rd_ptr];
          txd_n   = 1'b0;
          timer_n = '0;
          state_n = S_START;
        end
      end

      S_START: begin
        if (timer_end) begin
          timer_n = '0;
          idx_n   = '0;
          txd_n   = sh[0];
          state_n = S_DATA;
        end else begin
          timer_n = timer + TW'(1);
        end
      end

      S_DATA: begin
        if (timer_end) begin
          timer_n = '0;
          if (idx == 3'd7) begin
            txd_n   = 1'b1;
            state_n = S_STOP;
          end else begin
            // Drive the next bit straight from sh[1] so txd stays registered
            // while the shift register advances in the same edge.
            txd_n = sh[1];
            sh_n  = {1'b0, sh[7:1]};
            idx_n = idx + 3'd1;
          end
        end else begin
          timer_n = timer + TW'(1);
        end
      end

      S_STOP: begin
        if (timer_end) begin
          timer_n = '0;
          if (!fifo_empty) begin
            // Chain straight into the next start bit: no idle gap.
            pop     = 1'b1;
            sh_n    = mem[rd_ptr];
            txd_n   = 1'b0;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          timer_n = timer + TW'(1);
        end
      end

      default: begin
        txd_n   = 1'b1;
        timer_n = '0;
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard testbench for uart_tx_fifo

module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       sel;
  logic [7:0] wd;
  logic       wv;
  int         cpb;
  int         depth;

  logic       wv_a, wv_b;
  logic       wr_a, wr_b, txd_a, txd_b, busy_a, busy_b;
  logic [4:0] fc_a;
  logic [1:0] fc_b;
  logic       txd_m, busy_m, ready_m;
  logic [4:0] fc_m;

  assign wv_a    = wv && !sel;
  assign wv_b    = wv && sel;
  assign txd_m   = sel ? txd_b : txd_a;
  assign busy_m  = sel ? busy_b : busy_a;
  assign ready_m = sel ? wr_b : wr_a;
  assign fc_m    = sel ? {3'b000, fc_b} : fc_a;

  uart_tx_fifo #(.CLK_PER_BIT(5), .FIFO_DEPTH(16)) u_dut_a (
    .clk(clk), .rst(rst), .wr_data(wd), .wr_valid(wv_a), .wr_ready(wr_a),
    .txd(txd_a), .busy(busy_a), .fifo_count(fc_a)
  );

  uart_tx_fifo #(.CLK_PER_BIT(2), .FIFO_DEPTH(2)) u_dut_b (
    .clk(clk), .rst(rst), .wr_data(wd), .wr_valid(wv_b), .wr_ready(wr_b),
    .txd(txd_b), .busy(busy_b), .fifo_count(fc_b)
  );

  // Reference model: each accepted byte owns one frame starting at a known
  // edge; frames never overlap and never start before the edge after the push.
  typedef struct packed {
    logic [7:0] data;
    int         start;
  } ent_t;

  ent_t       exp_q[$];
  int         cyc = 0;
  int         last_end = 0;
  int         m_count = 0;
  int         accepted = 0;
  int         frames = 0;
  int         peak = 0;
  int         checks = 0;
  int         passes = 0;
  bit         rx_active = 1'b0;
  int         rx_k = 0;
  logic [7:0] rx_exp;
  logic       samp [64];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic finish_frame();
    logic [9:0] bits;
    logic [7:0] data;
    int ok;
    ok = 1;
    for (int b = 0; b < 10; b++) begin
      bits[b] = samp[b*cpb];
      for (int j = 1; j < cpb; j++)
        if (samp[b*cpb+j] !== bits[b]) ok = 0;
    end
    if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 0;
    for (int i = 0; i < 8; i++) data[i] = bits[i+1];
    chk("frame_shape", ok, 1);
    chk("frame_data", data, rx_exp);
    frames++;
    rx_active = 1'b0;
  endtask

  // Monitor: decodes txd, compares against the scoreboard queue, checks
  // the status outputs, then predicts acceptance for the coming edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        last_end  = 0;
        m_count   = 0;
        rx_active = 1'b0;
        chk("reset_txd", txd_m, 1);
        chk("reset_fifo_count", fc_m, 0);
        chk("reset_busy", busy_m, 0);
        chk("reset_wr_ready", ready_m, 1);
      end else begin
        int n;
        int cnt;
        n = cyc;
        if (rx_active) begin
          samp[rx_k] = txd_m;
          rx_k++;
          if (rx_k == 10*cpb) finish_frame();
        end else if (txd_m == 1'b0) begin
          chk("frame_start_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            ent_t e;
            e = exp_q.pop_front();
            chk("frame_start_cycle", n, e.start);
            rx_exp    = e.data;
            samp[0]   = 1'b0;
            rx_k      = 1;
            rx_active = 1'b1;
          end
        end
        cnt = 0;
        foreach (exp_q[i]) if (exp_q[i].start > n) cnt++;
        chk("fifo_count", fc_m, cnt);
        chk("wr_ready", ready_m, int'(cnt != depth));
        chk("busy", busy_m, int'((cnt != 0) || (n < last_end)));
        if (fc_m > peak) peak = fc_m;
        m_count = cnt;
        if (wv && cnt != depth) begin
          int s;
          s = (n + 2 > last_end) ? n + 2 : last_end;
          exp_q.push_back('{data: wd, start: s});
          last_end = s + 10*cpb;
          accepted++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_byte(input logic [7:0] b);
    wv = 1'b1;
    wd = b;
    tick();
    wv = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || rx_active || cyc < last_end) && k < budget) begin
      tick();
      k++;
    end
    chk("drain_within_budget", int'(k < budget), 1);
    repeat (3) tick();
  endtask

  task automatic random_traffic(input int cycles, input int pct);
    for (int i = 0; i < cycles; i++) begin
      wv = ($urandom_range(0, 99) < pct);
      wd = 8'($urandom);
      tick();
    end
    wv = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int f0, a0, c, k, target;
    logic [7:0] t2 [4];
    rst = 1'b0; wv = 1'b0; wd = 8'h00; sel = 1'b0; cpb = 5; depth = 16;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // Single byte, line idle
    f0 = frames;
    push_byte(8'h55);
    wait_idle(200);
    chk("t1_frames", frames - f0, 1);

    // Four consecutive pushes, contiguous frames
    t2[0] = 8'h04; t2[1] = 8'h04; t2[2] = 8'h0c; t2[3] = 8'h40;
    f0 = frames;
    for (int i = 0; i < 4; i++) begin
      wv = 1'b1;
      wd = t2[i];
      tick();
    end
    wv = 1'b0;
    wait_idle(400);
    chk("t2_frames", frames - f0, 4);

    // Overfill while busy, then push at count 15 on a STOP->START pop edge
    f0 = frames;
    peak = 0;
    push_byte(8'($urandom));
    wv = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wd = 8'($urandom);
      tick();
    end
    wv = 1'b0;
    chk("t3_peak_count", peak, 16);
    k = 0;
    while (m_count != 15 && k < 200) begin tick(); k++; end
    chk("t4_reached_15", m_count, 15);
    target = (exp_q.size() > 0) ? exp_q[0].start : cyc + 1;
    k = 0;
    while (cyc < target - 1 && k < 200) begin tick(); k++; end
    wv = 1'b1;
    wd = 8'($urandom);
    tick();
    wv = 1'b0;
    chk("t4_count_kept", fc_m, 15);
    wait_idle(2000);
    chk("t3_t4_frames", frames - f0, 18);

    // Reset mid-frame during data bit 3 of 0xA5 with three bytes queued
    f0 = frames;
    c = cyc;
    push_byte(8'hA5);
    wv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wd = 8'($urandom);
      tick();
    end
    wv = 1'b0;
    k = 0;
    while (cyc < c + 2 + 22 && k < 100) begin tick(); k++; end
    chk("t5_queued", fc_m, 3);
    rst = 1'b0;
    #1;
    chk("t5_async_txd", txd_m, 1);
    chk("t5_async_count", fc_m, 0);
    chk("t5_async_busy", busy_m, 0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (40) tick();
    chk("t5_no_frames", frames - f0, 0);

    // Randomised traffic, sparse then heavy
    f0 = frames;
    a0 = accepted;
    random_traffic(600, 2);
    random_traffic(900, 40);
    wait_idle(1200);
    chk("rand_a_frames", frames - f0, accepted - a0);

    // Small instance: two-clock bits, two-entry FIFO, pointer wrap
    sel = 1'b1; cpb = 2; depth = 2;
    tick();
    f0 = frames;
    a0 = accepted;
    push_byte(8'hFF);
    push_byte(8'h00);
    wait_idle(200);
    chk("t6_frames", frames - f0, 2);
    random_traffic(600, 40);
    wait_idle(200);
    chk("t6_rand_frames", frames - f0, accepted - a0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
